// File: rtl/check_ram_search_ctrl_if.sv
// Lookup/config/response channels between a TLB miss handler and the
// check RAM search controller.
//   req_*  : one translation lookup (valid/ready, address, access type)
//   cfg_*  : configuration write into the check RAM (valid/ready, addr, data)
//   resp_* : single hit/miss response (valid/ready plus latched hit info)
// The master modport is the requester side, slave is the controller side.
interface check_ram_search_ctrl_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_DATA_WIDTH = 32,
    parameter int RAM_AW         = 10
);
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [ADDR_WIDTH-1:0]     req_addr_i;
    logic                      req_rw_i;

    logic                      cfg_valid_i;
    logic                      cfg_ready_o;
    logic [RAM_AW-1:0]         cfg_addr_i;
    logic [RAM_DATA_WIDTH-1:0] cfg_wdata_i;

    logic                      resp_valid_o;
    logic                      resp_ready_i;
    logic                      resp_hit_o;
    logic [RAM_AW-1:0]         resp_hit_addr_o;
    logic                      resp_master_o;
    logic                      resp_multi_o;
    logic                      resp_prot_o;

    modport master (
        output req_valid_i, req_addr_i, req_rw_i,
        input  req_ready_o,
        output cfg_valid_i, cfg_addr_i, cfg_wdata_i,
        input  cfg_ready_o,
        input  resp_valid_o, resp_hit_o, resp_hit_addr_o,
               resp_master_o, resp_multi_o, resp_prot_o,
        output resp_ready_i
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_rw_i,
        output req_ready_o,
        input  cfg_valid_i, cfg_addr_i, cfg_wdata_i,
        output cfg_ready_o,
        output resp_valid_o, resp_hit_o, resp_hit_addr_o,
               resp_master_o, resp_multi_o, resp_prot_o,
        input  resp_ready_i
    );
endinterface

// File: rtl/check_ram_search_ctrl.sv
// Search sequencer for one dual-port check RAM slice of the L2 TLB.
// Accepts one lookup at a time, sweeps every offset of the addressed set on
// both RAM ports (port 0 = {0,set,off}, port 1 = {1,set,off}), watches the
// RAM hit result one cycle later and returns one hit/miss response.
// Config writes go to the RAM through port 0, only while idle.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   bus (slave)           req_* / cfg_* / resp_* channels
//   in_addr_o, rw_type_o  latched lookup address / access type to the RAM
//   ram_we_o, port0_addr_o, port1_addr_o, ram_wdata_o   RAM control
//   output_valid_o        RAM read data of the previous issue is valid
//   offset_addr_d_o       offset issued in the previous cycle
//   output_sent_o         response handshake pulse (releases RAM hit state)
//   hit_i, hit_addr_i, master_i, multi_hit_i, prot_i    RAM hit result
module check_ram_search_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_DATA_WIDTH = 32,
    parameter int PAGE_SIZE      = 4096,
    parameter int SET_WIDTH      = 5,
    parameter int OFFSET_WIDTH   = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    check_ram_search_ctrl_if.slave               bus,
    output logic [ADDR_WIDTH-1:0]                in_addr_o,
    output logic                                 rw_type_o,
    output logic                                 ram_we_o,
    output logic [SET_WIDTH+OFFSET_WIDTH:0]      port0_addr_o,
    output logic [SET_WIDTH+OFFSET_WIDTH:0]      port1_addr_o,
    output logic [RAM_DATA_WIDTH-1:0]            ram_wdata_o,
    output logic                                 output_valid_o,
    output logic [OFFSET_WIDTH-1:0]              offset_addr_d_o,
    output logic                                 output_sent_o,
    input  logic                                 hit_i,
    input  logic [SET_WIDTH+OFFSET_WIDTH:0]      hit_addr_i,
    input  logic                                 master_i,
    input  logic                                 multi_hit_i,
    input  logic                                 prot_i
);
    localparam int IGNORE_LSB = $clog2(PAGE_SIZE);
    localparam int RAM_AW     = SET_WIDTH + OFFSET_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DRAIN, S_RESP} state_t;

    state_t                  state_q;
    logic [OFFSET_WIDTH-1:0] off_q;
    logic                    issue_q;     // drives output_valid_o
    logic [OFFSET_WIDTH-1:0] off_d_q;
    logic                    resp_hit_q;
    logic [RAM_AW-1:0]       resp_addr_q;
    logic                    resp_master_q;
    logic                    resp_multi_q;
    logic                    resp_prot_q;

    logic [SET_WIDTH-1:0]    set_idx;
    logic                    is_idle;
    logic                    searching;
    logic                    hit_now;
    logic                    accept;

    assign set_idx   = in_addr_o[IGNORE_LSB +: SET_WIDTH];
    assign is_idle   = (state_q == S_IDLE);
    assign searching = (state_q == S_SEARCH);
    // hit_i is only meaningful for a cycle that carries valid read data
    assign hit_now   = issue_q & hit_i;

    // Config writes win over a lookup presented in the same idle cycle.
    assign bus.cfg_ready_o = is_idle;
    assign bus.req_ready_o = is_idle & ~bus.cfg_valid_i;
    assign ram_we_o        = is_idle & bus.cfg_valid_i;
    assign accept          = bus.req_valid_i & bus.req_ready_o;

    // Addresses are only driven while writing or sweeping; otherwise zero.
    assign port0_addr_o = ram_we_o  ? bus.cfg_addr_i :
                          searching ? {1'b0, set_idx, off_q} : '0;
    assign port1_addr_o = searching ? {1'b1, set_idx, off_q} : '0;
    assign ram_wdata_o  = ram_we_o  ? bus.cfg_wdata_i : '0;

    assign output_valid_o  = issue_q;
    assign offset_addr_d_o = off_d_q;

    assign bus.resp_valid_o    = (state_q == S_RESP);
    assign bus.resp_hit_o      = resp_hit_q;
    assign bus.resp_hit_addr_o = resp_addr_q;
    assign bus.resp_master_o   = resp_master_q;
    assign bus.resp_multi_o    = resp_multi_q;
    assign bus.resp_prot_o     = resp_prot_q;
    assign output_sent_o       = bus.resp_valid_o & bus.resp_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            off_q         <= '0;
            issue_q       <= 1'b0;
            off_d_q       <= '0;
            in_addr_o     <= '0;
            rw_type_o     <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_addr_q   <= '0;
            resp_master_q <= 1'b0;
            resp_multi_q  <= 1'b0;
            resp_prot_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    issue_q <= 1'b0;
                    if (accept) begin
                        in_addr_o <= bus.req_addr_i;
                        rw_type_o <= bus.req_rw_i;
                        off_q     <= '0;
                        state_q   <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    off_d_q <= off_q;
                    if (hit_now) begin
                        // The offset on the ports this cycle is thrown away.
                        issue_q       <= 1'b0;
                        resp_hit_q    <= 1'b1;
                        resp_addr_q   <= hit_addr_i;
                        resp_master_q <= master_i;
                        resp_multi_q  <= multi_hit_i;
                        resp_prot_q   <= prot_i;
                        state_q       <= S_RESP;
                    end else begin
                        issue_q <= 1'b1;
                        // Hold at the last offset; the sweep never wraps.
                        if (off_q == '1) state_q <= S_DRAIN;
                        else             off_q   <= off_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Last offset's data is on hit_i now; decide and respond.
                    issue_q       <= 1'b0;
                    resp_hit_q    <= hit_now;
                    resp_addr_q   <= hit_now ? hit_addr_i : '0;
                    resp_master_q <= hit_now & master_i;
                    resp_multi_q  <= hit_now & multi_hit_i;
                    resp_prot_q   <= hit_now & prot_i;
                    state_q       <= S_RESP;
                end
                S_RESP: begin
                    issue_q <= 1'b0;
                    if (bus.resp_ready_i) begin
                        resp_hit_q    <= 1'b0;
                        resp_addr_q   <= '0;
                        resp_master_q <= 1'b0;
                        resp_multi_q  <= 1'b0;
                        resp_prot_q   <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_check_ram_search_ctrl.sv
module tb_check_ram_search_ctrl;
    localparam int AW = 10;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    check_ram_search_ctrl_if #(.ADDR_WIDTH(32), .RAM_DATA_WIDTH(32), .RAM_AW(AW)) bus();

    logic [31:0]   in_addr;
    logic          rw_type, ram_we, output_valid, output_sent;
    logic [AW-1:0] port0_addr, port1_addr;
    logic [31:0]   ram_wdata;
    logic [3:0]    offset_addr_d;
    logic          hit, master, multi, prot;
    logic [AW-1:0] hit_addr;

    check_ram_search_ctrl dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .in_addr_o(in_addr), .rw_type_o(rw_type), .ram_we_o(ram_we),
        .port0_addr_o(port0_addr), .port1_addr_o(port1_addr),
        .ram_wdata_o(ram_wdata), .output_valid_o(output_valid),
        .offset_addr_d_o(offset_addr_d), .output_sent_o(output_sent),
        .hit_i(hit), .hit_addr_i(hit_addr), .master_i(master),
        .multi_hit_i(multi), .prot_i(prot)
    );

    // Check RAM contents, indexed by the full {port,set,offset} address.
    bit valid_tab  [1024];
    bit master_tab [1024];
    bit prot_tab   [1024];

    // Stand-in check RAM: one-cycle read latency, port 0 wins on double hit.
    always @(posedge clk) begin
        hit      <= valid_tab[port0_addr] | valid_tab[port1_addr];
        multi    <= valid_tab[port0_addr] & valid_tab[port1_addr];
        hit_addr <= valid_tab[port0_addr] ? port0_addr : port1_addr;
        master   <= valid_tab[port0_addr] ? master_tab[port0_addr] : master_tab[port1_addr];
        prot     <= valid_tab[port0_addr] ? prot_tab[port0_addr]   : prot_tab[port1_addr];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_tab();
        for (int i = 0; i < 1024; i++) begin
            valid_tab[i] = 1'b0; master_tab[i] = 1'b0; prot_tab[i] = 1'b0;
        end
    endtask

    task automatic put(input int port, input int set, input int off);
        int idx;
        idx = port * 512 + set * 16 + off;
        valid_tab[idx]  = 1'b1;
        master_tab[idx] = 1'($urandom_range(0, 1));
        prot_tab[idx]   = 1'($urandom_range(0, 1));
    endtask

    task automatic issue_req(input logic [31:0] addr, input bit rw);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        bus.req_rw_i    = rw;
        #1;
        chk("req_ready", bus.req_ready_o, 1'b1);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cfg_valid_i = 1'b1;
        bus.cfg_addr_i  = a;
        bus.cfg_wdata_i = d;
        #1;
        chk("cfg_we", {ram_we, port0_addr, ram_wdata}, {1'b1, a, d});
        @(posedge clk);
        #1;
        bus.cfg_valid_i = 1'b0;
    endtask

    // Called right after the accept edge; checks sweep, response and handshake.
    task automatic complete(input int set, input logic [31:0] addr, input bit rw, input int stall);
        int k_hit, idx, exp_cyc, exp_pulses, last_issue, cyc, pulses;
        bit e_hit, e_master, e_prot, e_multi, seen, addr_ok, offd_ok, gate_ok, hold_ok;
        logic [AW-1:0] e_addr;
        logic [3:0] pv;
        k_hit = -1; e_master = 0; e_prot = 0; e_multi = 0; e_addr = '0;
        for (int k = 0; k < N; k++) begin
            if (k_hit < 0 && (valid_tab[set*16+k] || valid_tab[512+set*16+k])) begin
                k_hit   = k;
                e_multi = valid_tab[set*16+k] & valid_tab[512+set*16+k];
                idx     = valid_tab[set*16+k] ? set*16+k : 512+set*16+k;
                e_master = master_tab[idx];
                e_prot   = prot_tab[idx];
                e_addr   = idx[AW-1:0];
            end
        end
        e_hit      = (k_hit >= 0);
        exp_cyc    = e_hit ? k_hit + 3 : N + 2;
        exp_pulses = e_hit ? k_hit + 1 : N;
        last_issue = e_hit ? ((k_hit + 2 > N) ? N : k_hit + 2) : N;

        cyc = 0; pulses = 0; seen = 0; addr_ok = 1; offd_ok = 1; gate_ok = 1;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.resp_valid_o) begin
                seen = 1;
                bus.cfg_valid_i = 1'b0;
            end else begin
                if (output_valid) begin
                    pv = pulses[3:0];
                    if (offset_addr_d !== pv) offd_ok = 0;
                    pulses++;
                end
                if (cyc <= last_issue &&
                    (port0_addr !== AW'(set*16 + cyc - 1) || port1_addr !== AW'(512 + set*16 + cyc - 1)))
                    addr_ok = 0;
                if (ram_we || bus.cfg_ready_o || bus.req_ready_o) gate_ok = 0;
                // config traffic while busy must be ignored
                bus.cfg_valid_i = 1'($urandom_range(0, 1));
                bus.cfg_addr_i  = AW'($urandom);
            end
        end
        if (!seen) begin
            chk("timeout", 1'b0, 1'b1);
            rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
            return;
        end
        chk("resp_cycle", cyc, exp_cyc);
        chk("ov_pulses", pulses, exp_pulses);
        chk("port_addr", addr_ok, 1'b1);
        chk("offset_d", offd_ok, 1'b1);
        chk("busy_gate", gate_ok, 1'b1);
        chk("in_addr", {rw_type, in_addr}, {rw, addr});
        chk("resp_hit", bus.resp_hit_o, e_hit);
        chk("resp_fields", {bus.resp_hit_addr_o, bus.resp_master_o, bus.resp_multi_o, bus.resp_prot_o},
            {e_addr, e_master, e_multi, e_prot});

        hold_ok = 1;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!bus.resp_valid_o || output_sent || output_valid || bus.resp_hit_o !== e_hit ||
                {bus.resp_hit_addr_o, bus.resp_master_o, bus.resp_multi_o, bus.resp_prot_o} !==
                {e_addr, e_master, e_multi, e_prot})
                hold_ok = 0;
        end
        chk("resp_hold", hold_ok, 1'b1);

        // Handshake; a request offered now must not be taken.
        bus.resp_ready_i = 1'b1;
        bus.req_valid_i  = 1'b1;
        #1;
        chk("sent_hs", {output_sent, bus.req_ready_o}, 2'b10);
        @(posedge clk);
        #1;
        bus.resp_ready_i = 1'b0;
        bus.req_valid_i  = 1'b0;
        @(negedge clk);
        chk("after_hs", {output_sent, bus.resp_valid_o, bus.req_ready_o, output_valid}, 4'b0010);
    endtask

    task automatic lookup(input int set, input int stall);
        logic [31:0] a;
        bit rw;
        a = $urandom;
        a[16:12] = 5'(set);
        rw = 1'($urandom_range(0, 1));
        issue_req(a, rw);
        complete(set, a, rw, stall);
    endtask

    initial begin
        logic [31:0] a;
        int set, ne;
        bus.req_valid_i = 0; bus.req_addr_i = 0; bus.req_rw_i = 0;
        bus.cfg_valid_i = 0; bus.cfg_addr_i = 0; bus.cfg_wdata_i = 0;
        bus.resp_ready_i = 0;
        clear_tab();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state after 5 idle cycles
        repeat (5) @(negedge clk);
        chk("rst_ctrl", {output_valid, output_sent, bus.resp_valid_o, ram_we, rw_type}, 5'b0);
        chk("rst_addr", {in_addr, port0_addr, port1_addr, offset_addr_d}, '0);
        chk("rst_resp", {bus.resp_hit_o, bus.resp_hit_addr_o, bus.resp_master_o, bus.resp_multi_o, bus.resp_prot_o}, '0);
        chk("rst_ready", {bus.req_ready_o, bus.cfg_ready_o}, 2'b11);

        // Config write and request together: config wins, request next cycle
        set = 3;
        a = 32'h0000_3000;
        put(1, 3, 5);
        bus.cfg_valid_i = 1'b1; bus.cfg_addr_i = 10'h025; bus.cfg_wdata_i = 32'hCAFE_0025;
        bus.req_valid_i = 1'b1; bus.req_addr_i = a; bus.req_rw_i = 1'b0;
        #1;
        chk("cfg_prio", {ram_we, port0_addr, ram_wdata, bus.req_ready_o}, {1'b1, 10'h025, 32'hCAFE_0025, 1'b0});
        @(posedge clk);
        #1;
        bus.cfg_valid_i = 1'b0;
        chk("not_taken", in_addr, 32'h0);
        // Hit at {1,3,5}, response held 4 cycles
        issue_req(a, 1'b0);
        complete(set, a, 1'b0, 4);

        // Empty set: full sweep, miss
        clear_tab();
        put(0, 9, 2); put(1, 4, 0);
        issue_req(32'h0000_5000, 1'b1);
        complete(5, 32'h0000_5000, 1'b1, 0);

        // Both ports at offset 15: hit found in DRAIN, port 0 reported
        clear_tab();
        put(0, 7, 15); put(1, 7, 15);
        issue_req(32'h0000_7abc, 1'b0);
        complete(7, 32'h0000_7abc, 1'b0, 1);

        // Reset in cycle 4 of a search
        clear_tab();
        put(0, 2, 10);
        issue_req(32'h0000_2000, 1'b0);
        repeat (3) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid", {output_valid, bus.resp_valid_o, bus.req_ready_o, in_addr}, {3'b001, 32'h0});
        begin
            bit quiet;
            quiet = 1;
            repeat (20) begin
                @(negedge clk);
                if (bus.resp_valid_o || output_valid) quiet = 0;
            end
            chk("rst_quiet", quiet, 1'b1);
        end
        lookup(2, 0);

        // Randomized lookups with noise in other sets
        for (int t = 0; t < 30; t++) begin
            clear_tab();
            set = $urandom_range(0, 31);
            ne = $urandom_range(0, 3);
            for (int e = 0; e < ne; e++)
                put($urandom_range(0, 1), set, $urandom_range(0, 15));
            for (int e = 0; e < 4; e++)
                put($urandom_range(0, 1), (set + 1 + $urandom_range(0, 30)) % 32, $urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0)
                cfg_write(AW'($urandom), $urandom);
            lookup(set, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
